// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store path and an external port.
// Default: CPU priority with a MAX_HOLD starvation bound; define DMEM_ARB_RR_EN for round-robin.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CPU  = 2'd1;
  localparam logic [1:0] EXT  = 2'd2;

  logic [1:0]            r_owner;
  logic [1:0]            w_owner_nxt;
  logic                  r_rd_pend;
  logic                  w_cpu_gnt;
  logic                  w_ext_gnt;
  logic                  w_ext_turn;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_ext_rdata;

`ifdef DMEM_ARB_RR_EN
  // On contention the side that did not own the memory last cycle wins.
  assign w_ext_turn = (r_owner == CPU);
`else
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] r_hold_cnt;

  assign w_ext_turn = (r_hold_cnt == HW'(MAX_HOLD));

  // Counts CPU wins against a waiting external request; any gap or ext win clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold_cnt <= '0;
    end else if (!ext_req || w_ext_gnt) begin
      r_hold_cnt <= '0;
    end else if (w_cpu_gnt && !w_ext_turn) begin
      r_hold_cnt <= r_hold_cnt + HW'(1);
    end
  end
`endif

  // Owner state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= IDLE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // Grant decision and next owner; grants are held off while reset is asserted.
  always_comb begin
    w_cpu_gnt   = 1'b0;
    w_ext_gnt   = 1'b0;
    w_owner_nxt = IDLE;
    if (reset) begin
      if (cpu_req && ext_req) begin
        w_ext_gnt = w_ext_turn;
        w_cpu_gnt = !w_ext_turn;
      end else begin
        w_cpu_gnt = cpu_req;
        w_ext_gnt = ext_req;
      end
    end
    if (w_cpu_gnt) begin
      w_owner_nxt = CPU;
    end else if (w_ext_gnt) begin
      w_owner_nxt = EXT;
    end
  end

  // Memory mux: idle bus is driven to zero.
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_gnt) begin
      mem_we    = cpu_we;
      mem_re    = !cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_ext_gnt) begin
      mem_we    = ext_we;
      mem_re    = !ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  // Read return: capture on the granted edge; the owner register steers rvalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_pend   <= 1'b0;
      r_cpu_rdata <= '0;
      r_ext_rdata <= '0;
    end else begin
      r_rd_pend <= mem_re;
      if (w_cpu_gnt && !cpu_we) begin
        r_cpu_rdata <= mem_rdata;
      end
      if (w_ext_gnt && !ext_we) begin
        r_ext_rdata <= mem_rdata;
      end
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign ext_gnt    = w_ext_gnt;
  assign cpu_stall  = cpu_req && !w_cpu_gnt;
  assign cpu_rvalid = r_rd_pend && (r_owner == CPU);
  assign ext_rvalid = r_rd_pend && (r_owner == EXT);
  assign cpu_rdata  = r_cpu_rdata;
  assign ext_rdata  = r_ext_rdata;

endmodule
